mac_vec_lanes: RTL and testbench

Parametrised multi-lane saturating multiply-accumulate engine for the fully-connected layer datapath. Each of LANES lanes multiplies a streamed operand pair through a MULT_STAGES-deep pipelined multiplier, saturates the product to T bits, and accumulates it with saturation over a programmed vector length. Results are presented through a valid/ready output handshake. It supersedes the single-lane, externally-sequenced MAC: enables, clearing and drain timing are generated internally by a control FSM.

---
 rtl/mac_vec_lanes_pkg.sv | 24 ++
 rtl/mac_vec_lanes_if.sv | 16 +
 rtl/mac_vec_lanes_lane.sv | 50 +++++
 rtl/mac_vec_lanes.sv | 67 ++++++
 tb/tb_mac_vec_lanes.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_vec_lanes_pkg.sv
// mac_pkg: FSM state type and saturation helpers shared by the MAC lanes and control.
package mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int MAXW = 64;
  function automatic logic signed [MAXW-1:0] smax(int t);
    return (MAXW'(1) <<< (t - 1)) - MAXW'(1);
  endfunction
  function automatic logic signed [MAXW-1:0] smin(int t);
    return -smax(t) - MAXW'(1);
  endfunction
  function automatic logic out_of_range(logic signed [MAXW-1:0] v, int t);
    return v > smax(t) || v < smin(t);
  endfunction
  function automatic logic signed [MAXW-1:0] clamp(logic signed [MAXW-1:0] v, int t);
    return v > smax(t) ? smax(t) : v < smin(t) ? smin(t) : v;
  endfunction
  function automatic logic signed [MAXW-1:0] sat_mul(logic signed [MAXW-1:0] p, int t);
    return clamp(p, t);
  endfunction
  // Addends are T-bit values sign-extended, so the exact sum never wraps in MAXW bits.
  function automatic logic signed [MAXW-1:0] sat_add(logic signed [MAXW-1:0] x, logic signed [MAXW-1:0] y, int t);
    return clamp(x + y, t);
  endfunction
endpackage

// File: rtl/mac_vec_lanes_if.sv
// mac_vec_lanes_if: control, operand stream and result handshake of the MAC engine.
interface mac_vec_lanes_if #(parameter int T = 14, parameter int LANES = 4, parameter int LEN_W = 8);
  logic start;
  logic [LEN_W-1:0] len;
  logic in_valid;
  logic in_ready;
  logic [LANES*T-1:0] a;
  logic [LANES*T-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [LANES*T-1:0] f;
  logic [LANES-1:0] sat_flag;
  logic busy;
  modport master(output start, len, in_valid, a, b, out_ready, input in_ready, out_valid, f, sat_flag, busy);
  modport slave(input start, len, in_valid, a, b, out_ready, output in_ready, out_valid, f, sat_flag, busy);
endinterface

// File: rtl/mac_vec_lanes_lane.sv
// mac_lane: pipelined multiplier with valid token, saturated product register and
// saturating accumulator with a sticky saturation flag.
module mac_lane
  import mac_pkg::*;
#(
  parameter int T = 14,
  parameter int MULT_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                in_v,
  input  logic signed [T-1:0] a,
  input  logic signed [T-1:0] b,
  output logic signed [T-1:0] acc,
  output logic                sat,
  output logic                busy
);
  logic signed [2*T-1:0] pipe [MULT_STAGES];
  logic [MULT_STAGES-1:0] pv;
  logic signed [T-1:0] prod;
  logic prod_v;
  logic prod_s;
  assign busy = |pv || prod_v;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MULT_STAGES; i++) pipe[i] <= '0;
      pv <= '0;
      prod <= '0;
      prod_v <= 1'b0;
      prod_s <= 1'b0;
      acc <= '0;
      sat <= 1'b0;
    end else begin
      pipe[0] <= (2*T)'(a) * (2*T)'(b);
      for (int i = 1; i < MULT_STAGES; i++) pipe[i] <= pipe[i-1];
      pv <= MULT_STAGES'({pv, in_v});
      prod <= T'(sat_mul(MAXW'(pipe[MULT_STAGES-1]), T));
      prod_s <= out_of_range(MAXW'(pipe[MULT_STAGES-1]), T);
      prod_v <= pv[MULT_STAGES-1];
      if (clr) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (prod_v) begin
        acc <= T'(sat_add(MAXW'(acc), MAXW'(prod), T));
        sat <= sat | prod_s | out_of_range(MAXW'(acc) + MAXW'(prod), T);
      end
    end
  end
endmodule

// File: rtl/mac_vec_lanes.sv
// mac_vec_lanes: multi-lane saturating MAC with internal sequencing FSM.
// Define MAC_RELU_EN to present negative accumulators as zero on f.
module mac_vec_lanes
  import mac_pkg::*;
#(
  parameter int T = 14,
  parameter int LANES = 4,
  parameter int MULT_STAGES = 2,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic reset_n,
  mac_vec_lanes_if.slave io
);
  state_t st;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LANES-1:0] lane_busy;
  logic signed [T-1:0] acc [LANES];
  logic fire;
  logic clr;
  assign fire = st == RUN && io.in_valid;
  assign clr = st == IDLE && io.start;
  assign io.in_ready = st == RUN;
  assign io.out_valid = st == DONE;
  assign io.busy = st != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      cnt <= '0;
      len_q <= '0;
    end else begin
      case (st)
        IDLE: if (io.start) begin
          cnt <= '0;
          len_q <= io.len;
          st <= io.len == '0 ? DONE : RUN;
        end
        RUN: if (io.in_valid) begin
          cnt <= cnt + LEN_W'(1);
          if (cnt == len_q - LEN_W'(1)) st <= DRAIN;
        end
        DRAIN: if (!(|lane_busy)) st <= DONE;
        DONE: if (io.out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.T(T), .MULT_STAGES(MULT_STAGES)) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .clr(clr),
      .in_v(fire),
      .a(io.a[i*T +: T]),
      .b(io.b[i*T +: T]),
      .acc(acc[i]),
      .sat(io.sat_flag[i]),
      .busy(lane_busy[i])
    );
`ifdef MAC_RELU_EN
    assign io.f[i*T +: T] = acc[i][T-1] ? '0 : acc[i];
`else
    assign io.f[i*T +: T] = acc[i];
`endif
  end
endmodule

// File: tb/tb_mac_vec_lanes.sv
// tb_mac_vec_lanes: randomized and directed vectors against a behavioural saturating-MAC model.
module tb_mac_vec_lanes;
  localparam int T = 14;
  localparam int L = 2;
  localparam int M = 2;
  localparam int W = 8;
  localparam int MAXV = 8191;
  localparam int MINV = -8192;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int va [16][L];
  int vb [16][L];
  int exp_raw [L];
  int exp_f [L];
  bit exp_sat [L];
  bit model_valid = 1'b0;
  bit gpat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mac_vec_lanes_if #(.T(T), .LANES(L), .LEN_W(W)) io();
  mac_vec_lanes #(.T(T), .LANES(L), .MULT_STAGES(M), .LEN_W(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(io.slave)
  );
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  function automatic int clampv(longint v, inout bit s);
    if (v > MAXV) begin s = 1'b1; return MAXV; end
    if (v < MINV) begin s = 1'b1; return MINV; end
    return int'(v);
  endfunction
  function automatic void model(int n);
    for (int i = 0; i < L; i++) begin
      int acc = 0;
      bit s = 1'b0;
      for (int k = 0; k < n; k++) begin
        int p = clampv(longint'(va[k][i]) * longint'(vb[k][i]), s);
        acc = clampv(longint'(acc) + longint'(p), s);
      end
      exp_raw[i] = acc;
      exp_sat[i] = s;
`ifdef MAC_RELU_EN
      exp_f[i] = acc < 0 ? 0 : acc;
`else
      exp_f[i] = acc;
`endif
    end
  endfunction
  always @(negedge clk) begin
    if (reset_n && io.out_valid) begin
      chk("result_expected", model_valid, 1);
      if (model_valid)
        for (int i = 0; i < L; i++) begin
          chk($sformatf("f_lane%0d", i), $signed(io.f[i*T +: T]), exp_f[i]);
          chk($sformatf("sat_lane%0d", i), io.sat_flag[i], exp_sat[i]);
        end
    end
  end
  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, io.out_valid, 0);
    chk({tag, "_in_ready"}, io.in_ready, 0);
    chk({tag, "_busy"}, io.busy, 0);
    chk({tag, "_f"}, io.f, 0);
    chk({tag, "_sat"}, io.sat_flag, 0);
  endtask
  task automatic drive_beat(input int idx);
    for (int i = 0; i < L; i++) begin
      io.a[i*T +: T] = T'(va[idx][i]);
      io.b[i*T +: T] = T'(vb[idx][i]);
    end
  endtask
  // gap: 0 full rate, 1 fixed 1,0,0,1,1 pattern, 2 random bubbles
  task automatic run_vec(input int n, input int gap, input int stall, input bit poke);
    int idx, s, t;
    bit fired;
    model(n);
    model_valid = 1'b1;
    io.start = 1'b1;
    io.len = W'(n);
    @(posedge clk);
    #1 io.start = 1'b0;
    s = cyc;
    if (n == 0) chk("len0_out_valid_next", io.out_valid, 1);
    idx = 0;
    t = 0;
    while (idx < n && t < 500) begin
      io.in_valid = gap == 0 ? 1'b1 : gap == 1 ? gpat[t % 5] : 1'($urandom_range(0, 1));
      drive_beat(idx);
      if (poke && t == 1) begin
        io.start = 1'b1;
        io.len = '0;
      end
      fired = io.in_valid && io.in_ready;
      @(posedge clk);
      #1 io.start = 1'b0;
      if (fired) idx++;
      t++;
    end
    io.in_valid = 1'b0;
    io.a = {L*T{1'b1}};
    io.b = {L*T{1'b1}};
    if (idx < n) chk("beats_accepted", idx, n);
    t = 0;
    while (!io.out_valid && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    chk("out_valid_seen", io.out_valid, 1);
    if (gap == 0 && n > 0) chk("latency", cyc - s, n + M + 2);
    repeat (stall) begin
      @(posedge clk);
      #1 chk("out_valid_hold", io.out_valid, 1);
    end
    io.out_ready = 1'b1;
    io.start = poke;
    io.len = W'(5);
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    io.start = 1'b0;
    model_valid = 1'b0;
    chk("out_valid_fall", io.out_valid, 0);
    chk("idle_after_handshake", io.busy, 0);
  endtask
  initial begin
    io.start = 1'b0;
    io.len = '0;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    va[0] = '{2, -1};  vb[0] = '{5, 10};
    va[1] = '{3, -2};  vb[1] = '{6, 10};
    va[2] = '{4, -3};  vb[2] = '{7, 10};
    model(3);
    chk("pin_dot_lane0", exp_raw[0], 56);
    chk("pin_dot_lane1", exp_raw[1], -60);
    run_vec(3, 0, 0, 1'b0);
    va[0] = '{200, -200}; vb[0] = '{100, 100};
    model(1);
    chk("pin_mul_max", exp_raw[0], MAXV);
    chk("pin_mul_min", exp_raw[1], MINV);
    chk("pin_mul_sat", exp_sat[0], 1);
    run_vec(1, 0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      va[k] = '{90, 1};
      vb[k] = '{90, 1};
    end
    model(3);
    chk("pin_acc_max", exp_raw[0], MAXV);
    chk("pin_acc_sat", exp_sat[0], 1);
    chk("pin_acc_lane1", exp_raw[1], 3);
    run_vec(3, 0, 0, 1'b0);
    va[0] = '{7, -9};  vb[0] = '{11, 4};
    va[1] = '{-5, 30}; vb[1] = '{6, -2};
    va[2] = '{12, 8};  vb[2] = '{12, 8};
    run_vec(3, 1, 5, 1'b0);
    run_vec(0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      va[k] = '{k + 1, -k};
      vb[k] = '{3, 7};
    end
    run_vec(4, 0, 2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      va[k] = '{200, -200};
      vb[k] = '{100, 100};
    end
    io.start = 1'b1;
    io.len = W'(3);
    @(posedge clk);
    #1 io.start = 1'b0;
    io.in_valid = 1'b1;
    drive_beat(0);
    @(posedge clk);
    #1 drive_beat(1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    io.in_valid = 1'b0;
    #1 chk_zero("midrun_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 chk_zero("after_reset");
    va[0] = '{3, -4}; vb[0] = '{4, 5};
    va[1] = '{-2, 6}; vb[1] = '{9, 1};
    run_vec(2, 0, 0, 1'b0);
    for (int r = 0; r < 24; r++) begin
      int n = $urandom_range(1, 8);
      bit wide = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++)
        for (int i = 0; i < L; i++) begin
          va[k][i] = wide ? int'($urandom_range(0, 16383)) - 8192 : int'($urandom_range(0, 255)) - 128;
          vb[k][i] = wide ? int'($urandom_range(0, 16383)) - 8192 : int'($urandom_range(0, 255)) - 128;
        end
      run_vec(n, r % 3 == 0 ? 0 : 2, $urandom_range(0, 3), r % 4 == 1 && n >= 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
